// File: rtl/alu_pkg.sv
// Shared definitions for the ALU writeback path: widths, logic function codes,
// legality check and the buffered entry layout.
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_REG_AW = 5;

    localparam logic [2:0] LOGIC_AND = 3'b000;
    localparam logic [2:0] LOGIC_XOR = 3'b001;
    localparam logic [2:0] LOGIC_SHL = 3'b010;
    localparam logic [2:0] LOGIC_SHR = 3'b011;
    localparam logic [2:0] LOGIC_SRA = 3'b100;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] result;
        logic [ALU_REG_AW-1:0] rd;
        logic                  wr_en;
        logic                  zero;
        logic                  neg;
        logic                  illegal;
    } entry_t;

    function automatic logic is_legal_func(input logic [2:0] func);
        return func inside {LOGIC_AND, LOGIC_XOR, LOGIC_SHL, LOGIC_SHR, LOGIC_SRA};
    endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// Generic 2-entry (head + skid) valid/ready buffer; 1-cycle latency through the head.
// Backpressure: ready is registered (!skid full), so nothing combinational from out_ready to in_ready.
module wb_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             skid_valid,
    output logic [WIDTH-1:0] skid_data
);

    logic accept;
    logic head_load;
    logic skid_valid_next;
    logic ready_q;

    assign accept    = in_valid & ready_q;
    assign head_load = !out_valid | out_ready;
    assign in_ready  = ready_q;

    // Skid only fills when the head cannot take the input; it empties into the head.
    assign skid_valid_next = skid_valid ? !head_load : (accept & !head_load);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            ready_q    <= 1'b0;
        end else begin
            if (head_load) begin
                if (skid_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= skid_data;
                end else if (accept) begin
                    out_valid <= 1'b1;
                    out_data  <= in_data;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (accept && !head_load) begin
                skid_data <= in_data;
            end
            skid_valid <= skid_valid_next;
            ready_q    <= !skid_valid_next;
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// Execute->writeback stage: tags ALU results, derives flags, squashes illegal/R0 writes, counts illegal ops.
// Latency 1 cycle when head free; 2-entry buffer, in_ready drops only when the skid entry is occupied.
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int REG_AW = ALU_REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [2:0]        in_func,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wr_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wr_en,
    output logic              out_zero,
    output logic              out_neg,
    output logic              out_illegal,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  illegal_cnt
);

    entry_t in_ent;
    entry_t head_ent;
    entry_t skid_ent;
    entry_t fwd_ent;
    logic   legal;
    logic   skid_valid;

    always_comb begin
        legal          = is_legal_func(in_func);
        in_ent         = '0;
        in_ent.result  = in_result;
        in_ent.rd      = in_rd;
        in_ent.wr_en   = in_wr_en & legal & (in_rd != '0);
        in_ent.zero    = (in_result == '0);
        in_ent.neg     = in_result[DATA_W-1];
        in_ent.illegal = !legal;
    end

    wb_skid_buf #(
        .WIDTH($bits(entry_t))
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_ent),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (head_ent),
        .skid_valid (skid_valid),
        .skid_data  (skid_ent)
    );

    assign out_result  = head_ent.result;
    assign out_rd      = head_ent.rd;
    assign out_wr_en   = head_ent.wr_en;
    assign out_zero    = head_ent.zero;
    assign out_neg     = head_ent.neg;
    assign out_illegal = head_ent.illegal;

    // Youngest buffered entry is the skid when occupied, otherwise the head.
    assign fwd_ent   = skid_valid ? skid_ent : head_ent;
    assign fwd_valid = (skid_valid | out_valid) & fwd_ent.wr_en;
    assign fwd_rd    = fwd_ent.rd;
    assign fwd_data  = fwd_ent.result;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (in_valid && in_ready && !legal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule
